// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives trial codes to an external
// R2R DAC and resolves one bit per SETTLE+1 cycles from a synchronized comparator.
module sar_adc_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_out,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int         IW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [IW-1:0] TOP_IDX  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DECIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              cmp_meta_r, cmp_sync_r;
  logic [3:0]        cnt_r, cnt_s;
  logic [IW-1:0]     idx_r, idx_s;
  logic [WIDTH-1:0]  dac_r, dac_s;
  logic [WIDTH-1:0]  result_r, result_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;

  assign dac_out = dac_r;
  assign result  = result_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_meta_r <= 1'b0;
      cmp_sync_r <= 1'b0;
    end else begin
      cmp_meta_r <= cmp_in;
      cmp_sync_r <= cmp_meta_r;
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= 4'd0;
      idx_r    <= '0;
      dac_r    <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      dac_r    <= dac_s;
      result_r <= result_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  // Next-state and datapath decode; abort takes priority over the bit decision.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    dac_s    = dac_r;
    result_s = result_r;
    case (state_r)
      S_IDLE: begin
        dac_s = '0;
        if (start && !abort) begin
          state_s        = S_SETTLE;
          idx_s          = TOP_IDX;
          dac_s[TOP_IDX] = 1'b1;
          cnt_s          = SETTLE_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_s = S_IDLE;
          dac_s   = '0;
        end else if (cnt_r == 4'd0) begin
          state_s = S_DECIDE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_DECIDE: begin
        if (abort) begin
          state_s = S_IDLE;
          dac_s   = '0;
        end else begin
          dac_s[idx_r] = cmp_sync_r;
          if (idx_r != '0) begin
            dac_s[idx_r - 1'b1] = 1'b1;
            idx_s               = idx_r - 1'b1;
            cnt_s               = SETTLE_LOAD;
            state_s             = S_SETTLE;
          end else begin
            result_s = dac_s;
            state_s  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        dac_s   = '0;
      end
      default: begin
        state_s = S_IDLE;
        dac_s   = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      S_SETTLE: busy_s = 1'b1;
      S_DECIDE: busy_s = 1'b1;
      S_DONE:   done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the DAC code and result width in bits.
REQ-002 Parameter SETTLE, default 4, SHALL set the cycles each trial code is held before the decision; legal range 3..15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a conversion; sampled only in IDLE.
REQ-006 abort  input  1  SHALL cancel a conversion in progress.
REQ-007 cmp_in  input  1  SHALL carry the external comparator output, asynchronous to clk: 1 = analog input >= DAC voltage.
REQ-008 dac_out  output  WIDTH  SHALL drive the trial code to the external R2R DAC, registered.
REQ-009 result  output  WIDTH  SHALL hold the last completed conversion, registered.
REQ-010 busy  output  1  SHALL be high in states SETTLE and DECIDE.
REQ-011 done  output  1  SHALL be a one-cycle pulse on conversion completion.

Function
REQ-012 cmp_in SHALL pass through a 2-flop synchronizer; DECIDE uses only the synchronized value.
REQ-013 The FSM SHALL have four states: IDLE, SETTLE, DECIDE and DONE.
REQ-014 In IDLE with start=1 and abort=0, the FSM SHALL do the following on one edge: go to SETTLE, set bit index = WIDTH-1, set dac_out = 1<<(WIDTH-1) (0x80), and load settle counter = SETTLE-1.
REQ-015 In SETTLE, each edge SHALL decrement the counter; an edge with counter = 0 SHALL go to DECIDE.
REQ-016 In DECIDE, one edge SHALL do the following: keep dac_out[index] if synced cmp = 1, else clear it. If index > 0, it SHALL also set dac_out[index-1], decrement index, reload the counter to SETTLE-1 and return to SETTLE. If index = 0, it SHALL copy the final code to result and go to DONE.
REQ-017 Per-bit time SHALL be SETTLE+1 cycles; with defaults, done SHALL be high for exactly the cycle after the 40th edge following the start-sampling edge.
REQ-018 In DONE, the FSM SHALL assert done=1 and busy=0 for one cycle, then go to IDLE; dac_out SHALL be 0 in IDLE.
REQ-019 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-020 abort=1 in SETTLE or DECIDE SHALL do the following on the next edge: go to IDLE, set dac_out = 0, leave result unchanged, and not pulse done.
REQ-021 abort=1 in IDLE or DONE SHALL have no effect beyond the normal DONE->IDLE transition.
REQ-022 In IDLE, start and abort both high SHALL be treated as abort; no conversion starts.
REQ-023 result SHALL change only on the DONE-entry edge and on reset.

Reset
REQ-024 When rst=1, state SHALL be IDLE and dac_out, result, busy, done, the counter, the index and the synchronizer flops SHALL all be 0, immediately and without a clock edge.
REQ-025 Reset asserted mid-conversion SHALL discard the conversion without a done pulse; the first start after release SHALL begin a fresh conversion at code 0x80.

Verification
REQ-026 Bench SHALL model the comparator as cmp_in = (vin >= dac_out) with default parameters: vin=0xA5, pulse start -> dac_out trials 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; result=0xA5; done 40 edges after start.
REQ-027 Bench SHALL run vin=0x00 and vin=0xFF -> result 0x00 and 0xFF respectively; exactly one done pulse each.
REQ-028 Bench SHALL pulse start again at trial 3 of a vin=0x5A conversion -> ignored; result 0x5A; done at the unchanged edge count.
REQ-029 Bench SHALL assert abort during bit 4 of a conversion -> next cycle busy=0 and dac_out=0; result keeps the prior value; no done pulse.
REQ-030 Bench SHALL assert rst asynchronously mid-conversion -> all outputs 0 immediately; a following start with vin=0x3C -> result 0x3C.
REQ-031 Bench SHALL drive start=abort=1 in IDLE -> busy stays 0, no done; the next start alone converts normally.
